// File: rtl/mem_access_sequencer_if.sv
// Request/response bus between mem_access_sequencer (master) and MemoryHierarchy (slave).
interface mem_access_sequencer_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] address;
  logic              MemRead;
  logic [DATA_W-1:0] data;
  logic              DataReady;
  logic              HMbar;

  modport master (output address, MemRead, input data, DataReady, HMbar);
  modport slave  (input address, MemRead, output data, DataReady, HMbar);
endinterface

// File: rtl/mem_access_sequencer.sv
// Walks a contiguous word-address block, one MemRead per word, gathering data and hit/miss stats.
// Optional running checksum of captured words when SEQ_CHECKSUM_EN is defined.
module mem_access_sequencer #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_W-1:0]     base_addr,
  input  logic [CNT_W-1:0]      length,
  mem_access_sequencer_if.master mem,
  output logic                  busy,
  output logic                  done,
  output logic                  rd_valid,
  output logic [DATA_W-1:0]     rd_data,
  output logic [CNT_W-1:0]      rd_index,
  output logic [CNT_W-1:0]      hit_count,
  output logic [CNT_W-1:0]      miss_count
`ifdef SEQ_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0]     checksum
`endif
);

  typedef enum logic [2:0] {IDLE, SETUP, REQ, GAP, DONE} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [CNT_W-1:0]  len_q, idx_q, rd_index_q, hit_q, miss_q;
  logic [DATA_W-1:0] rd_data_q;
  logic              rd_valid_q;
  logic              mem_rd;

  logic accept, capture, last;
  assign accept  = (state_q == IDLE) && start;
  assign capture = (state_q == REQ) && mem.DataReady;
  assign last    = (idx_q == len_q - CNT_W'(1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = (length != '0) ? SETUP : DONE;
      SETUP:   state_d = REQ;
      REQ:     if (mem.DataReady) state_d = last ? DONE : GAP;
      GAP:     state_d = REQ;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // MemRead is decoded straight from state so an async reset drops it at once.
  always_comb begin
    mem_rd = 1'b0;
    busy   = 1'b0;
    done   = 1'b0;
    case (state_q)
      SETUP:   busy = 1'b1;
      REQ:     begin busy = 1'b1; mem_rd = 1'b1; end
      GAP:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q     <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      rd_index_q <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= 1'b0;
      if (accept) begin
        if (length != '0) begin
          addr_q <= base_addr;
          len_q  <= length;
        end
        idx_q      <= '0;
        rd_index_q <= '0;
        hit_q      <= '0;
        miss_q     <= '0;
      end else if (capture) begin
        rd_data_q  <= mem.data;
        rd_valid_q <= 1'b1;
        rd_index_q <= idx_q;
        idx_q      <= idx_q + CNT_W'(1);
        if (mem.HMbar) hit_q  <= hit_q + CNT_W'(1);
        else           miss_q <= miss_q + CNT_W'(1);
        // Address wraps naturally at 2^ADDR_W.
        if (!last) addr_q <= addr_q + ADDR_W'(1);
      end
    end
  end

`ifdef SEQ_CHECKSUM_EN
  logic [DATA_W-1:0] csum_q;
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          csum_q <= '0;
    else if (accept)  csum_q <= '0;
    else if (capture) csum_q <= csum_q + mem.data;
  end
  assign checksum = csum_q;
`endif

  assign mem.address = addr_q;
  assign mem.MemRead = mem_rd;
  assign rd_valid    = rd_valid_q;
  assign rd_data     = rd_data_q;
  assign rd_index    = rd_index_q;
  assign hit_count   = hit_q;
  assign miss_count  = miss_q;

endmodule
